merge_pass_sequencer: RTL and testbench
=======================================

Name: merge_pass_sequencer

Overview:
- Bottom-up merge-sort controller that drives one merge core (two input FIFOs, one merged-output FIFO, start/done handshake) to sort N words held in an external single-port RAM.
- Each pass streams adjacent run pairs from the source bank into the core's two input FIFOs, runs one merge, and drains the merged run into the destination bank.
- Banks ping-pong between passes. Run width doubles each pass until one run covers N.

Parameters:
ADDR_W, 10, index width per bank; N max = 2^ADDR_W; merge core FIFOs must hold ≥ 2^(ADDR_W-1) words
DATA_W, 32, data word width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cfg_len  in  ADDR_W+1  element count N, sampled when sort_start is accepted
sort_start  in  1  request pulse; accepted only in IDLE
sort_busy  out  1  high from acceptance until sort_done
sort_done  out  1  one-cycle completion pulse
result_bank  out  1  bank holding the sorted result; valid from sort_done until the next acceptance
mem_addr  out  ADDR_W+1  {bank, index}
mem_rd_en  out  1  RAM read strobe; data on mem_rd_data next cycle
mem_rd_data  in  DATA_W  RAM read data
mem_wr_en  out  1  RAM write strobe
mem_wr_data  out  DATA_W  RAM write data
mrg_start  out  1  merge core start level
mrg_done  in  1  merge core done level
mrg_fifo_wr_data  out  DATA_W  shared input-FIFO write data
mrg_fifo1_wr_en  out  1  write run A into FIFO 1
mrg_fifo2_wr_en  out  1  write run B into FIFO 2
mrg_out_rd_en  out  1  merged-FIFO read strobe; data valid next cycle
mrg_out_rd_data  in  DATA_W  merged-FIFO read data

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including result_bank; internal counters cleared. Asserting reset mid-sort aborts with no sort_done. The merge core is reset separately.
- Registers: N, w (run width), i (pair offset), src (source bank), k (element counter), len1, len2.
- Accept: sort_start in IDLE. Capture N = min(cfg_len, 2^ADDR_W); set w=1, i=0, src=0; assert sort_busy.
  - If N ≤ 1: go to DONE next cycle. No memory or merge traffic.
  - Otherwise go to LOAD.
  - sort_start outside IDLE is ignored.
- Pair sizing at every LOAD entry: len1 = min(w, N-i); len2 = min(w, N-i-len1). len2 may be 0.
- LOAD:
  - For k = 0..len1+len2-1, one read per cycle: mem_rd_en=1, mem_addr={src, i+k}.
  - One cycle after each read, mrg_fifo_wr_data = mem_rd_data, with mrg_fifo1_wr_en if that element's k < len1, else mrg_fifo2_wr_en. Never both.
  - Duration: len1+len2+1 cycles. Then MERGE.
- MERGE:
  - Wait until mrg_done=0, then hold mrg_start=1 until mrg_done=1 is seen.
  - Next cycle: mrg_start=0, go to DRAIN.
  - mrg_done outside MERGE is ignored.
- DRAIN:
  - mrg_out_rd_en=1 for exactly len1+len2 consecutive cycles.
  - Each returned word (one cycle after its read) is written with mem_wr_en=1, mem_addr={~src, i+j}, j = 0.. in order.
  - Duration: len1+len2+1 cycles. Then NEXT.
  - mem_rd_en and mem_wr_en are never high in the same cycle.
- NEXT (1 cycle): i += 2w.
  - If i < N: go to LOAD.
  - Else: src = ~src, w <<= 1, i = 0. If w ≥ N: go to DONE; else go to LOAD.
- DONE (1 cycle): sort_done=1, result_bank=src, sort_busy=0 on exit, return to IDLE.
- Passes = ceil(log2 N). result_bank = passes mod 2.
- Arithmetic is ADDR_W+2 bits wide internally so i+2w never wraps. Equal keys are allowed; order among equal keys is unspecified.

Test Plan:
- ADDR_W=4, N=8, bank0=[5,3,8,1,9,2,7,4], pulse sort_start -> exactly 3 passes; sort_done once; result_bank=1; bank1=[1,2,3,4,5,7,8,9].
- N=5, bank0=[4,0,3,2,1] -> in pass 1 the pair i=4 has len1=1, len2=0 and mrg_fifo2_wr_en never fires for it; result_bank=1; bank1=[0,1,2,3,4].
- N=3, bank0=[7,7,1] -> 2 passes; result_bank=0; bank0=[1,7,7]; mem_rd_en and mem_wr_en never both high.
- N=1 and N=0 -> sort_done one cycle after acceptance; result_bank=0; no mem or mrg strobes.
- sort_start re-pulsed mid-sort (N=8) -> ignored; single sort_done; result identical to the first case.
- reset_n asserted while mrg_start=1 -> all outputs 0 immediately; IDLE; a new sort with N=4, bank0=[2,1,4,3] gives result_bank=0 and bank0=[1,2,3,4].

Source files
------------

// File: rtl/merge_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : merge_pass_sequencer
//  Purpose  : Bottom-up merge-sort controller. Streams adjacent run pairs from
//             the source RAM bank into a two-FIFO merge core, runs the merge,
//             drains the merged run into the other bank, and ping-pongs banks
//             while the run width doubles until one run covers N.
//  Revision : 1.0  initial release
// ============================================================================
module merge_pass_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              sort_start,
    output logic              sort_busy,
    output logic              sort_done,
    output logic              result_bank,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mrg_start,
    input  logic              mrg_done,
    output logic [DATA_W-1:0] mrg_fifo_wr_data,
    output logic              mrg_fifo1_wr_en,
    output logic              mrg_fifo2_wr_en,
    output logic              mrg_out_rd_en,
    input  logic [DATA_W-1:0] mrg_out_rd_data
);

    // Two spare bits so that i + 2w can never wrap.
    localparam int CW = ADDR_W + 2;

    localparam logic [CW-1:0]     c_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_NMAX    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MERGE = 3'd2,
        S_DRAIN = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_n,    w_n_nxt;
    logic [CW-1:0]   r_w,    w_w_nxt;
    logic [CW-1:0]   r_i,    w_i_nxt;
    logic [CW-1:0]   r_k,    w_k_nxt;
    logic [CW-1:0]   r_len1, w_len1_nxt;
    logic [CW-1:0]   r_len2, w_len2_nxt;
    logic            r_src,  w_src_nxt;
    logic            r_started, w_started_nxt;
    logic            r_result_bank, w_result_bank_nxt;

    logic [CW-1:0]     w_total;
    logic [CW-1:0]     w_rem;
    logic [CW-1:0]     w_i2;
    logic [CW-1:0]     w_w2;
    logic [ADDR_W-1:0] w_ld_idx;
    logic [ADDR_W-1:0] w_dr_idx;

    function automatic logic [CW-1:0] f_min(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Element count of the current pair and the RAM index for load/drain.
    // Indices stay below N <= 2^ADDR_W, so the low ADDR_W bits are exact.
    assign w_total  = r_len1 + r_len2;
    assign w_ld_idx = r_i[ADDR_W-1:0] + r_k[ADDR_W-1:0];
    assign w_dr_idx = w_ld_idx - c_IDX_ONE;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_n           <= '0;
            r_w           <= '0;
            r_i           <= '0;
            r_k           <= '0;
            r_len1        <= '0;
            r_len2        <= '0;
            r_src         <= 1'b0;
            r_started     <= 1'b0;
            r_result_bank <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_n           <= w_n_nxt;
            r_w           <= w_w_nxt;
            r_i           <= w_i_nxt;
            r_k           <= w_k_nxt;
            r_len1        <= w_len1_nxt;
            r_len2        <= w_len2_nxt;
            r_src         <= w_src_nxt;
            r_started     <= w_started_nxt;
            r_result_bank <= w_result_bank_nxt;
        end
    end

    // Next-state, datapath updates and all outputs.
    always_comb begin
        w_state_nxt       = r_state;
        w_n_nxt           = r_n;
        w_w_nxt           = r_w;
        w_i_nxt           = r_i;
        w_k_nxt           = r_k;
        w_len1_nxt        = r_len1;
        w_len2_nxt        = r_len2;
        w_src_nxt         = r_src;
        w_started_nxt     = r_started;
        w_result_bank_nxt = r_result_bank;
        w_rem             = '0;
        w_i2              = '0;
        w_w2              = '0;

        sort_busy         = (r_state != S_IDLE);
        sort_done         = 1'b0;
        result_bank       = r_result_bank;
        mem_addr          = '0;
        mem_rd_en         = 1'b0;
        mem_wr_en         = 1'b0;
        mem_wr_data       = '0;
        mrg_start         = 1'b0;
        mrg_fifo_wr_data  = '0;
        mrg_fifo1_wr_en   = 1'b0;
        mrg_fifo2_wr_en   = 1'b0;
        mrg_out_rd_en     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (sort_start) begin
                    w_n_nxt       = (cfg_len > c_NMAX) ? {1'b0, c_NMAX} : {1'b0, cfg_len};
                    w_w_nxt       = c_ONE;
                    w_i_nxt       = '0;
                    w_k_nxt       = '0;
                    w_src_nxt     = 1'b0;
                    w_started_nxt = 1'b0;
                    if (w_n_nxt <= c_ONE) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        // First pair with w=1, i=0 and N>=2 is always 1+1.
                        w_len1_nxt  = c_ONE;
                        w_len2_nxt  = c_ONE;
                        w_state_nxt = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                // Issue reads for k < total; each returned word lands one cycle later.
                if (r_k < w_total) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = {r_src, w_ld_idx};
                end
                if (r_k != '0) begin
                    mrg_fifo_wr_data = mem_rd_data;
                    if (r_k <= r_len1) mrg_fifo1_wr_en = 1'b1;
                    else               mrg_fifo2_wr_en = 1'b1;
                end
                if (r_k == w_total) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_MERGE;
                end else begin
                    w_k_nxt = r_k + c_ONE;
                end
            end

            S_MERGE: begin
                // Start is only raised once the core reports not-done.
                if (!r_started) begin
                    if (!mrg_done) w_started_nxt = 1'b1;
                end else begin
                    mrg_start = 1'b1;
                    if (mrg_done) begin
                        w_started_nxt = 1'b0;
                        w_state_nxt   = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (r_k < w_total) begin
                    mrg_out_rd_en = 1'b1;
                end
                if (r_k != '0) begin
                    mem_wr_en   = 1'b1;
                    mem_addr    = {~r_src, w_dr_idx};
                    mem_wr_data = mrg_out_rd_data;
                end
                if (r_k == w_total) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_NEXT;
                end else begin
                    w_k_nxt = r_k + c_ONE;
                end
            end

            S_NEXT: begin
                w_i2 = r_i + (r_w << 1);
                w_w2 = r_w << 1;
                if (w_i2 < r_n) begin
                    w_i_nxt     = w_i2;
                    w_rem       = r_n - w_i2;
                    w_len1_nxt  = f_min(r_w, w_rem);
                    w_len2_nxt  = f_min(r_w, w_rem - w_len1_nxt);
                    w_state_nxt = S_LOAD;
                end else begin
                    w_src_nxt = ~r_src;
                    w_w_nxt   = w_w2;
                    w_i_nxt   = '0;
                    if (w_w2 >= r_n) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rem       = r_n;
                        w_len1_nxt  = f_min(w_w2, w_rem);
                        w_len2_nxt  = f_min(w_w2, w_rem - w_len1_nxt);
                        w_state_nxt = S_LOAD;
                    end
                end
            end

            S_DONE: begin
                sort_done         = 1'b1;
                result_bank       = r_src;
                w_result_bank_nxt = r_src;
                w_state_nxt       = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_merge_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_merge_pass_sequencer
//  Purpose  : Directed testbench for merge_pass_sequencer with a behavioural
//             dual-bank RAM and a behavioural two-FIFO merge core.
//  Revision : 1.0  initial release
// ============================================================================
module tb_merge_pass_sequencer;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              clock;
    logic              reset_n;
    logic [ADDR_W:0]   cfg_len;
    logic              sort_start;
    logic              sort_busy;
    logic              sort_done;
    logic              result_bank;
    logic [ADDR_W:0]   mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mrg_start;
    logic              mrg_done;
    logic [DATA_W-1:0] mrg_fifo_wr_data;
    logic              mrg_fifo1_wr_en;
    logic              mrg_fifo2_wr_en;
    logic              mrg_out_rd_en;
    logic [DATA_W-1:0] mrg_out_rd_data;

    int checks = 0;
    int errors = 0;

    merge_pass_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cfg_len          (cfg_len),
        .sort_start       (sort_start),
        .sort_busy        (sort_busy),
        .sort_done        (sort_done),
        .result_bank      (result_bank),
        .mem_addr         (mem_addr),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_data      (mem_rd_data),
        .mem_wr_en        (mem_wr_en),
        .mem_wr_data      (mem_wr_data),
        .mrg_start        (mrg_start),
        .mrg_done         (mrg_done),
        .mrg_fifo_wr_data (mrg_fifo_wr_data),
        .mrg_fifo1_wr_en  (mrg_fifo1_wr_en),
        .mrg_fifo2_wr_en  (mrg_fifo2_wr_en),
        .mrg_out_rd_en    (mrg_out_rd_en),
        .mrg_out_rd_data  (mrg_out_rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Two-bank RAM, one-cycle read latency.
    logic [DATA_W-1:0] mem [0:31];
    always @(posedge clock) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Merge core model: merges FIFO1/FIFO2 a few cycles after start, holds
    // done until start drops.
    logic [DATA_W-1:0] f1 [$];
    logic [DATA_W-1:0] f2 [$];
    logic [DATA_W-1:0] oq [$];
    int mcnt;
    int merge_cnt;
    int merge_l1 [0:15];
    int merge_l2 [0:15];
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            f1.delete(); f2.delete(); oq.delete();
            mrg_done <= 1'b0;
            mrg_out_rd_data <= '0;
            mcnt <= 0;
        end else begin
            if (mrg_fifo1_wr_en) f1.push_back(mrg_fifo_wr_data);
            if (mrg_fifo2_wr_en) f2.push_back(mrg_fifo_wr_data);
            if (mrg_out_rd_en && oq.size() > 0) mrg_out_rd_data <= oq.pop_front();
            if (!mrg_start) begin
                mrg_done <= 1'b0;
                mcnt <= 0;
            end else if (!mrg_done) begin
                if (mcnt == 3) begin
                    if (merge_cnt < 16) begin
                        merge_l1[merge_cnt] = f1.size();
                        merge_l2[merge_cnt] = f2.size();
                    end
                    merge_cnt = merge_cnt + 1;
                    while (f1.size() > 0 || f2.size() > 0) begin
                        if (f2.size() == 0 || (f1.size() > 0 && f1[0] <= f2[0]))
                            oq.push_back(f1.pop_front());
                        else
                            oq.push_back(f2.pop_front());
                    end
                    mrg_done <= 1'b1;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    // Activity monitor sampled on the falling edge.
    int done_cnt, rd_cnt, wr_cnt, f1_cnt, f2_cnt, both_cnt, fboth_cnt, mstrobe_cnt;
    always @(negedge clock) begin
        if (sort_done) done_cnt++;
        if (mem_rd_en) rd_cnt++;
        if (mem_wr_en) wr_cnt++;
        if (mrg_fifo1_wr_en) f1_cnt++;
        if (mrg_fifo2_wr_en) f2_cnt++;
        if (mem_rd_en && mem_wr_en) both_cnt++;
        if (mrg_fifo1_wr_en && mrg_fifo2_wr_en) fboth_cnt++;
        if (mrg_start || mrg_out_rd_en) mstrobe_cnt++;
    end

    task automatic clear_stats();
        done_cnt = 0; rd_cnt = 0; wr_cnt = 0; f1_cnt = 0; f2_cnt = 0;
        both_cnt = 0; fboth_cnt = 0; mstrobe_cnt = 0; merge_cnt = 0;
    endtask

    task automatic clear_mem();
        for (int j = 0; j < 32; j++) mem[j] = 32'hEEEE_0000 + j;
    endtask

    task automatic start_sort(input int n);
        @(negedge clock);
        cfg_len    = n[ADDR_W:0];
        sort_start = 1'b1;
        @(negedge clock);
        sort_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (!sort_done && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (!sort_done) begin
            errors++;
            $display("FAIL %s_timeout: sort_done absent after %0d cycles, expected a pulse", name, cyc);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        checks++;
        if (sort_busy !== 1'b0 || sort_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", sort_busy, sort_done);
        end
        checks++;
        if (result_bank !== 1'b0) begin
            errors++;
            $display("FAIL reset_result_bank: got %b expected 0", result_bank);
        end
        checks++;
        if ({mem_rd_en, mem_wr_en, mrg_start, mrg_fifo1_wr_en, mrg_fifo2_wr_en, mrg_out_rd_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {mem_rd_en, mem_wr_en, mrg_start, mrg_fifo1_wr_en, mrg_fifo2_wr_en, mrg_out_rd_en});
        end
        checks++;
        if (mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr);
        end
    endtask

    task automatic test_sort8();
        logic [31:0] vin [8] = '{5, 3, 8, 1, 9, 2, 7, 4};
        logic [31:0] vex [8] = '{1, 2, 3, 4, 5, 7, 8, 9};
        clear_mem();
        for (int j = 0; j < 8; j++) mem[j] = vin[j];
        clear_stats();
        start_sort(8);
        checks++;
        if (sort_busy !== 1'b1) begin
            errors++;
            $display("FAIL sort8_busy: got %b expected 1", sort_busy);
        end
        wait_done("sort8");
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL sort8_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (result_bank !== 1'b1) begin errors++; $display("FAIL sort8_result_bank: got %b expected 1", result_bank); end
        checks++;
        if (merge_cnt !== 7) begin errors++; $display("FAIL sort8_merges: got %0d expected 7", merge_cnt); end
        checks++;
        if (rd_cnt !== 24 || wr_cnt !== 24) begin
            errors++;
            $display("FAIL sort8_traffic: got rd=%0d wr=%0d expected 24 24", rd_cnt, wr_cnt);
        end
        checks++;
        if (sort_busy !== 1'b0) begin errors++; $display("FAIL sort8_idle_busy: got %b expected 0", sort_busy); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (mem[16 + j] !== vex[j]) begin
                errors++;
                $display("FAIL sort8_bank1[%0d]: got %0d expected %0d", j, mem[16 + j], vex[j]);
            end
        end
    endtask

    task automatic test_trivial();
        for (int t = 0; t < 2; t++) begin
            clear_stats();
            start_sort(1 - t);
            checks++;
            if (sort_done !== 1'b1) begin
                errors++;
                $display("FAIL trivial_n%0d_done: got %b expected 1 one cycle after accept", 1 - t, sort_done);
            end
            @(negedge clock);
            checks++;
            if (sort_done !== 1'b0 || sort_busy !== 1'b0 || result_bank !== 1'b0) begin
                errors++;
                $display("FAIL trivial_n%0d_after: got done=%b busy=%b bank=%b expected 0 0 0",
                         1 - t, sort_done, sort_busy, result_bank);
            end
            repeat (2) @(negedge clock);
            checks++;
            if (rd_cnt + wr_cnt + f1_cnt + f2_cnt + mstrobe_cnt !== 0) begin
                errors++;
                $display("FAIL trivial_n%0d_strobes: got %0d strobes expected 0", 1 - t,
                         rd_cnt + wr_cnt + f1_cnt + f2_cnt + mstrobe_cnt);
            end
        end
    endtask

    task automatic test_odd5();
        logic [31:0] vin [5] = '{4, 0, 3, 2, 1};
        clear_mem();
        for (int j = 0; j < 5; j++) mem[j] = vin[j];
        clear_stats();
        start_sort(5);
        wait_done("odd5");
        checks++;
        if (result_bank !== 1'b1) begin errors++; $display("FAIL odd5_result_bank: got %b expected 1", result_bank); end
        checks++;
        if (merge_cnt !== 6) begin errors++; $display("FAIL odd5_merges: got %0d expected 6", merge_cnt); end
        checks++;
        if (merge_l1[2] !== 1 || merge_l2[2] !== 0) begin
            errors++;
            $display("FAIL odd5_tail_pair: got len1=%0d len2=%0d expected 1 0", merge_l1[2], merge_l2[2]);
        end
        checks++;
        if (f1_cnt !== 10 || f2_cnt !== 5 || fboth_cnt !== 0) begin
            errors++;
            $display("FAIL odd5_fifo_writes: got f1=%0d f2=%0d both=%0d expected 10 5 0", f1_cnt, f2_cnt, fboth_cnt);
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (mem[16 + j] !== 32'(j)) begin
                errors++;
                $display("FAIL odd5_bank1[%0d]: got %0d expected %0d", j, mem[16 + j], j);
            end
        end
    endtask

    task automatic test_three();
        logic [31:0] vin [3] = '{7, 7, 1};
        logic [31:0] vex [3] = '{1, 7, 7};
        clear_mem();
        for (int j = 0; j < 3; j++) mem[j] = vin[j];
        clear_stats();
        start_sort(3);
        wait_done("three");
        checks++;
        if (result_bank !== 1'b0) begin errors++; $display("FAIL three_result_bank: got %b expected 0", result_bank); end
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL three_rd_wr_overlap: got %0d cycles expected 0", both_cnt); end
        checks++;
        if (merge_cnt !== 3) begin errors++; $display("FAIL three_merges: got %0d expected 3", merge_cnt); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (mem[j] !== vex[j]) begin
                errors++;
                $display("FAIL three_bank0[%0d]: got %0d expected %0d", j, mem[j], vex[j]);
            end
        end
    endtask

    task automatic test_restart();
        logic [31:0] vin [8] = '{5, 3, 8, 1, 9, 2, 7, 4};
        logic [31:0] vex [8] = '{1, 2, 3, 4, 5, 7, 8, 9};
        clear_mem();
        for (int j = 0; j < 8; j++) mem[j] = vin[j];
        clear_stats();
        start_sort(8);
        repeat (20) @(negedge clock);
        cfg_len    = 5'd3;
        sort_start = 1'b1;
        @(negedge clock);
        sort_start = 1'b0;
        wait_done("restart");
        repeat (40) @(negedge clock);
        checks++;
        if (done_cnt !== 1 || sort_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_single_done: got done_cnt=%0d busy=%b expected 1 0", done_cnt, sort_busy);
        end
        checks++;
        if (result_bank !== 1'b1) begin errors++; $display("FAIL restart_result_bank: got %b expected 1", result_bank); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (mem[16 + j] !== vex[j]) begin
                errors++;
                $display("FAIL restart_bank1[%0d]: got %0d expected %0d", j, mem[16 + j], vex[j]);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] vin [8] = '{5, 3, 8, 1, 9, 2, 7, 4};
        logic [31:0] vn4 [4] = '{2, 1, 4, 3};
        int cyc = 0;
        clear_mem();
        for (int j = 0; j < 8; j++) mem[j] = vin[j];
        clear_stats();
        start_sort(8);
        while (mrg_start !== 1'b1 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (mrg_start !== 1'b1) begin
            errors++;
            $display("FAIL abort_wait_start: mrg_start=%b after %0d cycles expected 1", mrg_start, cyc);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({sort_busy, sort_done, result_bank, mem_rd_en, mem_wr_en, mrg_start, mrg_fifo1_wr_en,
             mrg_fifo2_wr_en, mrg_out_rd_en, mem_addr, mem_wr_data, mrg_fifo_wr_data} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b bank=%b start=%b addr=%0d expected all 0",
                     sort_busy, sort_done, result_bank, mrg_start, mem_addr);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (done_cnt !== 0 || sort_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done_cnt=%0d busy=%b expected 0 0", done_cnt, sort_busy);
        end
        clear_mem();
        for (int j = 0; j < 4; j++) mem[j] = vn4[j];
        clear_stats();
        start_sort(4);
        wait_done("abort_resort");
        checks++;
        if (result_bank !== 1'b0) begin errors++; $display("FAIL abort_result_bank: got %b expected 0", result_bank); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (mem[j] !== 32'(j + 1)) begin
                errors++;
                $display("FAIL abort_bank0[%0d]: got %0d expected %0d", j, mem[j], j + 1);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        sort_start = 1'b0;
        cfg_len    = '0;
        clear_mem();
        clear_stats();
        repeat (3) @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        test_sort8();
        test_trivial();
        test_odd5();
        test_three();
        test_restart();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
